mem_access_ctrl: RTL and testbench

- Sequencer between the MEM pipeline stage and the word-only data memory (256 x 32, word-indexed by address[9:2]; read data updates on the falling edge when read is enabled, writes commit on the rising edge).
- Translates byte/halfword/word loads and stores (RISC-V funct3 encoding) into word accesses.
- Performs read-modify-write for sub-word stores and sign/zero extends load data.
- Stalls the pipeline until each access completes.
- Detects misaligned, illegal and out-of-range requests.

---
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/halfword/word loads and stores from the MEM
// stage onto a word-only data memory. Sub-word stores use read-modify-write,
// loads are lane-extracted and sign/zero extended, and the pipeline is stalled
// until each access finishes. Misaligned, illegal and out-of-range requests
// complete in one cycle with a fault flag and never touch memory.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [1:0]  i_ctrlMEM,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_loadData,
    output logic        o_misaligned,
    output logic        o_accessFault,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWriteData,
    output logic [1:0]  o_memCtrl,
    input  logic [31:0] i_memReadData
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    // First byte address past the end of memory.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_storeData;
    logic [31:0] r_oldWord;
    logic [31:0] r_loadData;
    logic        r_misaligned;
    logic        r_accessFault;

    logic        w_isLoad;
    logic        w_isStore;
    logic        w_accessFault;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadExt;
    logic [31:0] w_merged;

    // Classify the incoming request; access faults outrank misalignment.
    always_comb begin
        w_isLoad      = (i_ctrlMEM == 2'b10);
        w_isStore     = (i_ctrlMEM == 2'b01);
        w_accessFault = ~(w_isLoad | w_isStore)
                      | (w_isLoad  & (i_funct3 inside {3'b011, 3'b110, 3'b111}))
                      | (w_isStore & ~(i_funct3 inside {3'b000, 3'b001, 3'b010}))
                      | ({1'b0, i_addr} >= ADDR_LIMIT);
        w_misaligned  = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                      | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    end

    // Extract and extend the addressed lane of the word being read.
    always_comb begin
        w_byte = i_memReadData[{r_addr[1:0], 3'b000} +: 8];
        w_half = i_memReadData[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'h000000, w_byte};
            3'b101:  w_loadExt = {16'h0000, w_half};
            default: w_loadExt = i_memReadData;
        endcase
    end

    // Splice the store byte/halfword into the previously read word.
    always_comb begin
        w_merged = r_oldWord;
        if (r_funct3[0]) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_storeData[15:0];
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_storeData[7:0];
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and memory-side outputs decoded from the current state.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_nextState    = r_state;
        o_memCtrl      = 2'b00;
        o_memWriteData = 32'h0;
        o_memAddr      = {r_addr[31:2], 2'b00};
        o_done         = 1'b0;
        o_misaligned   = 1'b0;
        o_accessFault  = 1'b0;
        case (r_state)
            IDLE: begin
                o_memAddr = 32'h0;
                if (i_req) begin
                    if (w_accessFault | w_misaligned) w_nextState = RESP;
                    else if (w_isLoad)                w_nextState = READ;
                    else if (i_funct3 == 3'b010)      w_nextState = WRITE;
                    else                              w_nextState = RMW_RD;
                end
            end
            READ: begin
                o_memCtrl   = 2'b10;
                w_nextState = RESP;
            end
            WRITE: begin
                o_memCtrl      = 2'b01;
                o_memWriteData = r_storeData;
                w_nextState    = RESP;
            end
            RMW_RD: begin
                o_memCtrl   = 2'b10;
                w_nextState = RMW_WR;
            end
            RMW_WR: begin
                o_memCtrl      = 2'b01;
                o_memWriteData = w_merged;
                w_nextState    = RESP;
            end
            RESP: begin
                o_done        = 1'b1;
                o_misaligned  = r_misaligned;
                o_accessFault = r_accessFault;
                w_nextState   = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture in IDLE, load result and old-word capture from memory.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr        <= 32'h0;
            r_funct3      <= 3'b000;
            r_storeData   <= 32'h0;
            r_oldWord     <= 32'h0;
            r_loadData    <= 32'h0;
            r_misaligned  <= 1'b0;
            r_accessFault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_addr        <= i_addr;
                        r_funct3      <= i_funct3;
                        r_storeData   <= i_storeData;
                        r_accessFault <= w_accessFault;
                        r_misaligned  <= w_misaligned & ~w_accessFault;
                    end
                end
                READ:    r_loadData <= w_loadExt;
                RMW_RD:  r_oldWord  <= i_memReadData;
                default: ;
            endcase
        end
    end

    assign o_loadData = r_loadData;
    assign o_stall    = i_req & ~o_done;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a word memory model answers the
// DUT's memory port, while a byte-level reference model predicts load values,
// memory contents, flags and latency for each request.
module tb_mem_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req;
    logic [1:0]  i_ctrlMEM;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_storeData;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_loadData;
    logic        o_misaligned;
    logic        o_accessFault;
    logic [31:0] o_memAddr;
    logic [31:0] o_memWriteData;
    logic [1:0]  o_memCtrl;
    logic [31:0] i_memReadData;

    mem_access_ctrl #(.MEM_WORDS(256)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_ctrlMEM      (i_ctrlMEM),
        .i_funct3       (i_funct3),
        .i_addr         (i_addr),
        .i_storeData    (i_storeData),
        .o_stall        (o_stall),
        .o_done         (o_done),
        .o_loadData     (o_loadData),
        .o_misaligned   (o_misaligned),
        .o_accessFault  (o_accessFault),
        .o_memAddr      (o_memAddr),
        .o_memWriteData (o_memWriteData),
        .o_memCtrl      (o_memCtrl),
        .i_memReadData  (i_memReadData)
    );

    always #5 i_clk = ~i_clk;

    // Data memory as seen by the DUT: read on the falling edge, write on the rising edge.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    always @(negedge i_clk) if (o_memCtrl[1]) i_memReadData <= mem[o_memAddr[9:2]];
    always @(posedge i_clk) if (o_memCtrl[0]) mem[o_memAddr[9:2]] <= o_memWriteData;

    int n_cmp = 0;
    int n_err = 0;
    logic        checking = 1'b0;
    logic [31:0] ref_load = 32'h0;
    int          last_lat;
    logic        last_mis;
    logic        last_flt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle interface invariants.
    always @(negedge i_clk) begin
        if (checking && !i_reset) begin
            check("stall", {31'b0, o_stall}, {31'b0, i_req & ~o_done});
            check("memctrl_both", {31'b0, o_memCtrl == 2'b11}, 32'h0);
            check("memaddr_align", {30'b0, o_memAddr[1:0]}, 32'h0);
        end
    end

    // Issue one request (called at a falling edge) and compare its completion
    // against the reference model. b2b=1 means i_req stayed high from the
    // previous request and the DUT is currently in its response cycle.
    task automatic do_req(input logic [1:0] ctrl, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input bit b2b);
        bit          is_ld, is_st, flt, mis, got;
        int          size, lat, exp_rd, exp_wr, rd, wr, cyc, idx, off;
        logic [31:0] word, val;
        i_ctrlMEM = ctrl; i_funct3 = f3; i_addr = addr; i_storeData = data; i_req = 1'b1;

        is_ld = (ctrl == 2'b10);
        is_st = (ctrl == 2'b01);
        flt = !(is_ld || is_st) || (addr >= 32'd1024)
            || (is_ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            || (is_st && !(f3 inside {3'd0, 3'd1, 3'd2}));
        size = 1 << f3[1:0];
        mis  = !flt && ((addr % size) != 0);
        idx  = int'(addr[9:2]);
        off  = int'(addr[1:0]);
        exp_rd = 0; exp_wr = 0;
        if (flt || mis) begin
            lat = 1;
        end else if (is_ld) begin
            lat = 2; exp_rd = 1;
            word = ref_mem[idx] >> (8 * off);
            val = (size == 1) ? (word & 32'hFF) : (size == 2) ? (word & 32'hFFFF) : word;
            if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFFFF00;
            if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF0000;
            ref_load = val;
        end else begin
            lat = (size == 4) ? 2 : 3;
            exp_rd = (size == 4) ? 0 : 1;
            exp_wr = 1;
            word = ref_mem[idx];
            for (int i = 0; i < size; i++) word[(off + i) * 8 +: 8] = data[i * 8 +: 8];
            ref_mem[idx] = word;
        end

        rd = 0; wr = 0; cyc = 0; got = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            cyc++;
            if (o_memCtrl[1]) rd++;
            if (o_memCtrl[0]) wr++;
            if (o_done) begin got = 1; break; end
        end
        if (!got) begin
            check("done_timeout", {31'b0, o_done}, 32'h1);
        end else begin
            check("latency", cyc, lat + int'(b2b));
            check("misaligned", {31'b0, o_misaligned}, {31'b0, mis});
            check("access_fault", {31'b0, o_accessFault}, {31'b0, flt});
            check("rd_cycles", rd, exp_rd);
            check("wr_cycles", wr, exp_wr);
            if (is_ld || flt || mis) check("load_data", o_loadData, ref_load);
            if (!flt && !mis && is_st) check("mem_word", mem[idx], ref_mem[idx]);
        end
        last_lat = cyc - int'(b2b);
        last_mis = o_misaligned;
        last_flt = o_accessFault;
    endtask

    // Drop i_req after a completion and idle for 'gap' extra cycles.
    task automatic idle_gap(input int gap);
        i_req = 1'b0;
        repeat (gap + 1) @(negedge i_clk);
    endtask

    logic [31:0] saved;

    initial begin
        i_reset = 1'b1; i_req = 1'b0; i_ctrlMEM = 2'b00; i_funct3 = 3'b000;
        i_addr = 32'h0; i_storeData = 32'h0; i_memReadData = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge i_clk);
        check("rst_done", {31'b0, o_done}, 32'h0);
        check("rst_flags", {30'b0, o_misaligned, o_accessFault}, 32'h0);
        check("rst_memctrl", {30'b0, o_memCtrl}, 32'h0);
        check("rst_loaddata", o_loadData, 32'h0);
        check("rst_memaddr", o_memAddr, 32'h0);
        check("rst_memwdata", o_memWriteData, 32'h0);
        i_reset = 1'b0;
        checking = 1'b1;
        @(negedge i_clk);

        // Word write then load.
        do_req(2'b01, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        check("lit_sw_lat", last_lat, 2);
        idle_gap(0);
        do_req(2'b10, 3'b010, 32'h10, 32'h0, 0);
        check("lit_lw", o_loadData, 32'hDEADBEEF);
        idle_gap(1);

        // Sub-word load extension.
        do_req(2'b01, 3'b010, 32'h10, 32'h80FF7F01, 0); idle_gap(0);
        do_req(2'b10, 3'b000, 32'h13, 32'h0, 0); check("lit_lb", o_loadData, 32'hFFFFFF80); idle_gap(0);
        do_req(2'b10, 3'b100, 32'h13, 32'h0, 0); check("lit_lbu", o_loadData, 32'h00000080); idle_gap(0);
        do_req(2'b10, 3'b001, 32'h12, 32'h0, 0); check("lit_lh", o_loadData, 32'hFFFF80FF); idle_gap(0);
        do_req(2'b10, 3'b101, 32'h10, 32'h0, 0); check("lit_lhu", o_loadData, 32'h00007F01); idle_gap(0);

        // Read-modify-write stores.
        do_req(2'b01, 3'b010, 32'h20, 32'h11223344, 0); idle_gap(0);
        do_req(2'b01, 3'b000, 32'h21, 32'h000000AB, 0);
        check("lit_sb_lat", last_lat, 3);
        check("lit_sb_mem", mem[8], 32'h1122AB44);
        idle_gap(0);
        do_req(2'b01, 3'b001, 32'h22, 32'h0000CAFE, 0);
        check("lit_sh_mem", mem[8], 32'hCAFEAB44);
        idle_gap(0);

        // Faults leave o_loadData at the last loaded value (LHU above).
        do_req(2'b10, 3'b010, 32'h02, 32'h0, 0);
        check("lit_lw_mis", {30'b0, last_mis, last_flt}, 32'h2);
        check("lit_fault_lat", last_lat, 1);
        idle_gap(0);
        do_req(2'b01, 3'b000, 32'h400, 32'h55, 0);
        check("lit_sb_range", {30'b0, last_mis, last_flt}, 32'h1);
        idle_gap(0);
        do_req(2'b11, 3'b010, 32'h40, 32'h0, 0);
        check("lit_ctrl11", {30'b0, last_mis, last_flt}, 32'h1);
        check("lit_fault_load", o_loadData, 32'h00007F01);
        idle_gap(0);

        // Reset in the middle of a read-modify-write.
        saved = ref_mem[12];
        i_ctrlMEM = 2'b01; i_funct3 = 3'b000; i_addr = 32'h30; i_storeData = 32'hEE; i_req = 1'b1;
        @(negedge i_clk);
        check("rmw_rd_ctrl", {30'b0, o_memCtrl}, 32'h2);
        i_reset = 1'b1;
        #1;
        check("midrst_ctrl", {30'b0, o_memCtrl}, 32'h0);
        check("midrst_flags", {29'b0, o_done, o_misaligned, o_accessFault}, 32'h0);
        check("midrst_outs", o_loadData | o_memAddr | o_memWriteData, 32'h0);
        i_req = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        ref_load = 32'h0;
        @(negedge i_clk);
        check("midrst_mem", mem[12], saved);
        do_req(2'b10, 3'b010, 32'h30, 32'h0, 0);
        check("lit_lw_after_rst", o_loadData, saved);
        idle_gap(0);

        // Back-to-back LW then SW with i_req held high.
        do_req(2'b10, 3'b010, 32'h20, 32'h0, 0);
        do_req(2'b01, 3'b010, 32'h24, 32'h0BADF00D, 1);
        check("lit_b2b_sw", mem[9], 32'h0BADF00D);
        idle_gap(0);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            int          r;
            logic [1:0]  c;
            logic [31:0] a;
            bit          b2b;
            r = int'($urandom_range(0, 9));
            c = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01;
            r = int'($urandom_range(0, 19));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h3FC + 32'($urandom_range(0, 7));
            else if (r < 12) a = {22'h0, 8'($urandom), 2'b00};
            else             a = {22'h0, 10'($urandom)};
            b2b = (t > 0) && ($urandom_range(0, 2) == 0);
            if (!b2b && t > 0) idle_gap(int'($urandom_range(0, 2)));
            do_req(c, 3'($urandom), a, $urandom, b2b);
        end
        idle_gap(1);

        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
